// File: rtl/fifo_1r1w_sync_param.sv
// Single-clock FIFO. The producer side uses valid/ready and the consumer side uses valid/yumi.
// The head word is held in a register, so data_o comes straight from a flop.
module fifo_1r1w_sync_param #(
    parameter int width_p        = 8,
    parameter int els_p          = 5,
    parameter int almost_full_p  = 4,
    parameter int almost_empty_p = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         valid_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         yumi_i,
    input  logic                         flush_i,
    output logic [$clog2(els_p+1)-1:0]   count_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic                         error_o
);

    localparam int cw_lp = $clog2(els_p + 1);
    localparam int pw_lp = $clog2(els_p);

    localparam logic [cw_lp-1:0] els_lp      = cw_lp'(els_p);
    localparam logic [cw_lp-1:0] one_lp      = cw_lp'(1);
    localparam logic [cw_lp-1:0] af_lp       = cw_lp'(almost_full_p);
    localparam logic [cw_lp-1:0] ae_lp       = cw_lp'(almost_empty_p);
    localparam logic [pw_lp-1:0] ptr_last_lp = pw_lp'(els_p - 1);

    logic [width_p-1:0] mem_r [els_p];
    logic [pw_lp-1:0]   wr_ptr_r;
    logic [pw_lp-1:0]   rd_ptr_r;
    logic [pw_lp-1:0]   rd_ptr_inc;
    logic [pw_lp-1:0]   wr_ptr_inc;
    logic [cw_lp-1:0]   count_r;
    logic [width_p-1:0] data_r;
    logic               error_r;
    logic               underflow;
    logic               enq;
    logic               deq;

    assign ready_o        = (count_r < els_lp);
    assign valid_o        = (count_r != '0);
    assign data_o         = data_r;
    assign count_o        = count_r;
    assign almost_full_o  = (count_r >= af_lp);
    assign almost_empty_o = (count_r <= ae_lp);
    assign error_o        = error_r;

    // An underflow cycle is ignored entirely, apart from setting the sticky error flag.
    assign underflow = yumi_i & ~valid_o;
    assign enq       = valid_i & ready_o & ~flush_i & ~underflow;
    assign deq       = yumi_i & valid_o & ~flush_i;

    assign rd_ptr_inc = (rd_ptr_r == ptr_last_lp) ? '0 : rd_ptr_r + pw_lp'(1);
    assign wr_ptr_inc = (wr_ptr_r == ptr_last_lp) ? '0 : wr_ptr_r + pw_lp'(1);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            data_r   <= '0;
            error_r  <= 1'b0;
        end else if (flush_i) begin
            count_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (underflow) begin
            error_r  <= 1'b1;
        end else begin
            case ({enq, deq})
                2'b10:   count_r <= count_r + one_lp;
                2'b01:   count_r <= count_r - one_lp;
                default: count_r <= count_r;
            endcase
            if (enq)
                wr_ptr_r <= wr_ptr_inc;
            if (deq)
                rd_ptr_r <= rd_ptr_inc;
            // When the queue is empty, or is emptied and refilled in the same cycle, the incoming word becomes the head.
            if (enq && ((count_r == '0) || (deq && (count_r == one_lp))))
                data_r <= data_i;
            else if (deq && (count_r > one_lp))
                data_r <= mem_r[rd_ptr_inc];
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq)
            mem_r[wr_ptr_r] <= data_i;
    end

endmodule

// File: tb/tb_fifo_1r1w_sync_param.sv
// Directed, table-driven bench for fifo_1r1w_sync_param with its default parameters.
// A short streaming loop and an asynchronous reset sequence cover the multi-cycle cases.
module tb_fifo_1r1w_sync_param;

    localparam int W   = 8;
    localparam int ELS = 5;
    localparam int AF  = 4;
    localparam int AE  = 1;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [W-1:0] data_i;
    logic         valid_i;
    logic         ready_o;
    logic         valid_o;
    logic [W-1:0] data_o;
    logic         yumi_i;
    logic         flush_i;
    logic [2:0]   count_o;
    logic         almost_full_o;
    logic         almost_empty_o;
    logic         error_o;

    int n_checks = 0;
    int n_errors = 0;

    fifo_1r1w_sync_param #(
        .width_p(W), .els_p(ELS), .almost_full_p(AF), .almost_empty_p(AE)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .yumi_i(yumi_i),
        .flush_i(flush_i), .count_o(count_o), .almost_full_o(almost_full_o),
        .almost_empty_o(almost_empty_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         y;
        logic         f;
        int           cnt;
        logic [W-1:0] dat;
        logic         err;
    } vec_t;

    vec_t tbl[$];
    int   split;

    task automatic add(input logic v, input logic [W-1:0] d, input logic y, input logic f,
                       input int cnt, input logic [W-1:0] dat, input logic err);
        vec_t t;
        t.v = v; t.d = d; t.y = y; t.f = f; t.cnt = cnt; t.dat = dat; t.err = err;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Flags and handshake outputs follow from the expected occupancy.
    task automatic chk_state(input string nm, input int cnt, input logic [W-1:0] dat, input logic err);
        chk({nm, " count"}, 32'(count_o), 32'(cnt));
        chk({nm, " valid"}, 32'(valid_o), 32'(cnt > 0));
        chk({nm, " ready"}, 32'(ready_o), 32'(cnt < ELS));
        chk({nm, " afull"}, 32'(almost_full_o), 32'(cnt >= AF));
        chk({nm, " aempty"}, 32'(almost_empty_o), 32'(cnt <= AE));
        chk({nm, " error"}, 32'(error_o), 32'(err));
        if (cnt > 0)
            chk({nm, " data"}, 32'(data_o), 32'(dat));
    endtask

    task automatic apply(input logic v, input logic [W-1:0] d, input logic y, input logic f);
        valid_i = v; data_i = d; yumi_i = y; flush_i = f;
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_vec(input int i);
        apply(tbl[i].v, tbl[i].d, tbl[i].y, tbl[i].f);
        chk_state($sformatf("v%0d", i), tbl[i].cnt, tbl[i].dat, tbl[i].err);
    endtask

    initial begin
        logic [W-1:0] model[$];

        // fill, back-pressure, drain
        add(1, 8'h11, 0, 0, 1, 8'h11, 0);
        add(1, 8'h22, 0, 0, 2, 8'h11, 0);
        add(1, 8'h33, 0, 0, 3, 8'h11, 0);
        add(1, 8'h44, 0, 0, 4, 8'h11, 0);
        add(1, 8'h55, 0, 0, 5, 8'h11, 0);
        add(1, 8'h66, 0, 0, 5, 8'h11, 0);
        add(0, 8'h00, 1, 0, 4, 8'h22, 0);
        add(0, 8'h00, 1, 0, 3, 8'h33, 0);
        add(0, 8'h00, 1, 0, 2, 8'h44, 0);
        add(0, 8'h00, 1, 0, 1, 8'h55, 0);
        add(0, 8'h00, 1, 0, 0, 8'h00, 0);
        // bypass at count 1, then build to count 3
        add(1, 8'hA0, 0, 0, 1, 8'hA0, 0);
        add(1, 8'hB0, 1, 0, 1, 8'hB0, 0);
        add(1, 8'hC0, 0, 0, 2, 8'hB0, 0);
        add(1, 8'hC1, 0, 0, 3, 8'hB0, 0);
        split = tbl.size();
        // full plus yumi: EE must not be stored
        add(1, 8'hE1, 0, 0, 4, 8'hD9, 0);
        add(1, 8'hE2, 0, 0, 5, 8'hD9, 0);
        add(1, 8'hEE, 1, 0, 4, 8'hDA, 0);
        add(0, 8'h00, 1, 0, 3, 8'hDB, 0);
        add(0, 8'h00, 1, 0, 2, 8'hE1, 0);
        add(0, 8'h00, 1, 0, 1, 8'hE2, 0);
        add(0, 8'h00, 1, 0, 0, 8'h00, 0);
        // flush overrides enqueue and dequeue
        add(1, 8'h01, 0, 0, 1, 8'h01, 0);
        add(1, 8'h02, 0, 0, 2, 8'h01, 0);
        add(1, 8'h03, 0, 0, 3, 8'h01, 0);
        add(1, 8'h99, 1, 1, 0, 8'h00, 0);
        add(1, 8'h77, 0, 0, 1, 8'h77, 0);
        add(0, 8'h00, 1, 0, 0, 8'h00, 0);
        // underflow: sticky error, no state change, survives flush
        add(1, 8'h5B, 1, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 1, 0, 8'h00, 1);
        add(1, 8'h5A, 0, 0, 1, 8'h5A, 1);

        reset_n_i = 1'b0; valid_i = 0; data_i = '0; yumi_i = 0; flush_i = 0;
        #2;
        chk_state("reset", 0, 8'h00, 0);
        chk("reset data", 32'(data_o), 32'h0);
        #10 reset_n_i = 1'b1;

        for (int i = 0; i < split; i++)
            run_vec(i);

        // streaming at count 3 across two pointer wraps
        model.push_back(8'hB0); model.push_back(8'hC0); model.push_back(8'hC1);
        for (int k = 0; k < 12; k++) begin
            apply(1, 8'hD0 + 8'(k), 1, 0);
            model.push_back(8'hD0 + 8'(k));
            void'(model.pop_front());
            chk_state($sformatf("stream%0d", k), 3, model[0], 0);
        end

        for (int i = split; i < tbl.size(); i++)
            run_vec(i);

        // asynchronous reset mid-operation, away from any clock edge
        valid_i = 0; yumi_i = 0; flush_i = 0;
        #1 reset_n_i = 1'b0;
        #1;
        chk_state("async_reset", 0, 8'h00, 0);
        chk("async_reset data", 32'(data_o), 32'h0);
        #1 reset_n_i = 1'b1;
        apply(1, 8'h66, 0, 0);
        chk_state("post_reset", 1, 8'h66, 0);
        apply(0, 8'h00, 1, 0);
        chk_state("post_reset_drain", 0, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_1r1w_sync_param.md
FIFO_1R1W_SYNC_PARAM -- requirements
Module: fifo_1r1w_sync_param

Interface
REQ-001 SHALL have parameter: width_p, 8, data word width in bits (>=1).
REQ-002 SHALL have parameter: els_p, 5, storage depth in entries (>=2, any integer, not restricted to powers of two).
REQ-003 SHALL have parameter: almost_full_p, 4, occupancy at or above which almost_full_o asserts (1..els_p).
REQ-004 SHALL have parameter: almost_empty_p, 1, occupancy at or below which almost_empty_o asserts (0..els_p-1).
REQ-005 SHALL have port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port: reset_n_i  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: data_i  input  width_p  write data.
REQ-008 SHALL have port: valid_i  input  1  write request (valid-ready protocol).
REQ-009 SHALL have port: ready_o  output  1  FIFO can accept a word this cycle.
REQ-010 SHALL have port: valid_o  output  1  data_o holds the head entry (valid-yumi protocol).
REQ-011 SHALL have port: data_o  output  width_p  head entry, driven from a register.
REQ-012 SHALL have port: yumi_i  input  1  consumer takes the head this cycle; may depend combinationally on valid_o/data_o.
REQ-013 SHALL have port: flush_i  input  1  synchronous clear of all queued entries.
REQ-014 SHALL have port: count_o  output  $clog2(els_p+1)  current occupancy.
REQ-015 SHALL have port: almost_full_o  output  1  count_o >= almost_full_p.
REQ-016 SHALL have port: almost_empty_o  output  1  count_o <= almost_empty_p.
REQ-017 SHALL have port: error_o  output  1  sticky protocol-violation flag.

Function
REQ-018 SHALL assert ready_o exactly when count < els_p and valid_o exactly when count > 0; both derive from registers only, with no combinational path from valid_i, yumi_i or flush_i.
REQ-019 SHALL enqueue when valid_i & ready_o, and dequeue when yumi_i & valid_o.
REQ-020 SHALL give a write-to-read latency of 1 cycle: a word enqueued into an empty FIFO appears on data_o with valid_o=1 in the next cycle.
REQ-021 SHALL update count on each edge: +1 for enqueue only, -1 for dequeue only, unchanged for both or neither.
REQ-022 SHALL advance each pointer from els_p-1 to 0 on wrap-around, for any els_p.
REQ-023 SHALL, on simultaneous enqueue and dequeue with count=1, load data_i into data_o for the next cycle (bypass); with count>1, load the entry after the head.
REQ-024 SHALL keep ready_o=0 when full, so no enqueue occurs even if a dequeue happens in the same cycle (no full-state bypass).
REQ-025 SHALL keep data_o stable while valid_o=1 and no dequeue occurs.
REQ-026 SHALL, when flush_i=1, override any enqueue or dequeue that cycle and discard them; next cycle count=0, both pointers=0, valid_o=0, ready_o=1.
REQ-027 SHALL leave error_o unchanged on flush_i.
REQ-028 SHALL set error_o to 1 and hold it until reset when yumi_i=1 while valid_o=0; that cycle SHALL change no state.
REQ-029 SHALL treat valid_i=1 while ready_o=0 as legal back-pressure: no write, no error.
REQ-030 SHALL compute almost_full_o and almost_empty_o from the registered count, valid in the same cycle as count_o.

Reset
REQ-031 SHALL, when reset_n_i=0, immediately set count_o=0, pointers=0, valid_o=0, ready_o=1, data_o=0, almost_empty_o=1, almost_full_o=0 and error_o=0, regardless of clk_i.
REQ-032 SHALL not reset the storage array; its contents are don't-care after reset.
REQ-033 SHALL, on reset asserted mid-operation, discard all queued data; the first enqueue after reset_n_i rises is the next word delivered.

Verification
REQ-034 SHALL cover fill and drain (els_p=5, width_p=8): enqueue 0x11..0x55 -> ready_o=0 after fifth, almost_full_o=1 at count 4; drain -> data_o 0x11..0x55 in order, valid_o=0 after last.
REQ-035 SHALL cover wrap-around: 12 streaming cycles of simultaneous enqueue and dequeue at count=3 -> count_o stays 3 and output order matches input order across two pointer wraps.
REQ-036 SHALL cover the bypass case: with count=1 (head 0xA0), enqueue 0xB0 and dequeue in the same cycle -> next cycle data_o=0xB0, count_o=1.
REQ-037 SHALL cover full plus yumi: at count=5, valid_i=1 with 0xEE and yumi_i=1 -> count_o=4 and 0xEE is not stored.
REQ-038 SHALL cover flush: at count=3, flush_i=1 together with valid_i and yumi_i -> next cycle count_o=0, valid_o=0, and the next enqueue of 0x77 appears on data_o one cycle later.
REQ-039 SHALL cover the underflow error: yumi_i=1 while empty -> error_o=1 and stays 1 through flush; count_o stays 0; reset clears error_o to 0.
